// File: rtl/drum_step_clock.sv
// Tempo and step generator: converts the active BPM into an eight-step bar
// using a phase accumulator, and produces the slowed step clock, the step
// index and the per-step and per-bar pulses for the drum datapath.
module drum_step_clock #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned STEPS_PER_BEAT = 2,
  parameter int unsigned BPM_MIN        = 30,
  parameter int unsigned BPM_MAX        = 240,
  parameter int unsigned BPM_RESET      = 60,
  parameter int unsigned ACC_W          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       ld_bpm,
  input  logic [7:0] bpm_in,
  output logic [2:0] timing,
  output logic       step_clk,
  output logic       step_tick,
  output logic       bar_start,
  output logic       running,
  output logic [7:0] bpm_out
);

  // One step is CLK_HZ*60 phase units; computed in 64 bits so large clock
  // rates do not overflow before being cut down to the accumulator width.
  localparam logic [ACC_W-1:0] THRESH  = ACC_W'(64'(CLK_HZ) * 64'd60);
  localparam logic [ACC_W-1:0] HALF    = THRESH >> 1;
  localparam logic [7:0]       MIN_B   = 8'(BPM_MIN);
  localparam logic [7:0]       MAX_B   = 8'(BPM_MAX);
  localparam logic [7:0]       RESET_B = 8'(BPM_RESET);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       bpm_active_q, bpm_active_d;
  logic [7:0]       bpm_pend_q, bpm_pend_d;
  logic [2:0]       timing_q, timing_d;
  logic             tick_q, tick_d;
  logic             bar_q, bar_d;

  logic [7:0]       bpm_clamped;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] sum;
  logic             boundary;

  // Clamp the requested BPM into the supported tempo range.
  always_comb begin
    bpm_clamped = bpm_in;
    if (bpm_in < MIN_B) begin
      bpm_clamped = MIN_B;
    end else if (bpm_in > MAX_B) begin
      bpm_clamped = MAX_B;
    end
  end

  assign inc      = ACC_W'(bpm_active_q) * ACC_W'(STEPS_PER_BEAT);
  assign sum      = acc_q + inc;
  assign boundary = (sum >= THRESH);

  // State register and datapath registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      bpm_active_q <= RESET_B;
      bpm_pend_q   <= RESET_B;
      timing_q     <= 3'd0;
      tick_q       <= 1'b0;
      bar_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bpm_active_q <= bpm_active_d;
      bpm_pend_q   <= bpm_pend_d;
      timing_q     <= timing_d;
      tick_q       <= tick_d;
      bar_q        <= bar_d;
    end
  end

  // Next-state logic: accumulate phase in RUN, roll steps at each threshold
  // crossing and only swap in a new tempo on a step boundary.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    bpm_active_d = bpm_active_q;
    bpm_pend_d   = bpm_pend_q;
    timing_d     = timing_q;
    tick_d       = 1'b0;
    bar_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_d    = '0;
        timing_d = 3'd0;
        // While stopped a tempo load is applied immediately.
        if (ld_bpm) begin
          bpm_pend_d   = bpm_clamped;
          bpm_active_d = bpm_clamped;
        end
        if (play) begin
          state_d = ST_RUN;
          tick_d  = 1'b1;
          bar_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (ld_bpm) begin
          bpm_pend_d = bpm_clamped;
        end
        if (!play) begin
          // Stopping has priority over a boundary landing on the same edge.
          state_d  = ST_IDLE;
          acc_d    = '0;
          timing_d = 3'd0;
        end else if (boundary) begin
          // Keep the remainder so the long-run step rate is exact; the
          // boundary uses the pending tempo as it stood before this edge.
          acc_d        = sum - THRESH;
          timing_d     = timing_q + 3'd1;
          tick_d       = 1'b1;
          bar_d        = (timing_q == 3'd7);
          bpm_active_d = bpm_pend_q;
        end else begin
          acc_d = sum;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign running   = (state_q == ST_RUN);
  assign step_clk  = (state_q == ST_RUN) && (acc_q < HALF);
  assign timing    = timing_q;
  assign step_tick = tick_q;
  assign bar_start = bar_q;
  assign bpm_out   = bpm_active_q;

endmodule
